eceg_encryptor: RTL

- Sequential EC-ElGamal encryption engine; the forward direction of the point-subtraction decryption path (M = C2 - priv*C1).
- Computes C1 = k*G and C2 = M + k*Q from message point M, ephemeral scalar k, generator G and recipient public key Q.
- Scalar multiplication is MSB-first double-and-add.
- Uses two existing combinational PointAdder instances, one per accumulator. PointAdder handles doubling when P==Q.

---
 rtl/eceg_encryptor.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/eceg_encryptor.sv
// EC-ElGamal encryption engine: C1 = k*G, C2 = M + k*Q, MSB-first double-and-add.
// Optional ECEG_CONSTTIME_EN: fixed-latency schedule (ADD cycle spent for every bit).
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif
`ifndef ECC_P
`define ECC_P 17
`endif
`ifndef ECC_A
`define ECC_A 2
`endif

// Combinational affine point adder over GF(ECC_P); doubles when both operands match.
module PointAdder (
  input  logic [`DATAWIDTH-1:0] x1,
  input  logic [`DATAWIDTH-1:0] y1,
  input  logic [`DATAWIDTH-1:0] x2,
  input  logic [`DATAWIDTH-1:0] y2,
  output logic [`DATAWIDTH-1:0] x3,
  output logic [`DATAWIDTH-1:0] y3,
  output logic                  inf
);
  localparam int W = `DATAWIDTH;
  localparam logic [W-1:0] PM    = W'(`ECC_P);
  localparam logic [W-1:0] AC    = W'(`ECC_A);
  localparam logic [W-1:0] THREE = W'(3);

  function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, PM}) s = s - {1'b0, PM};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] fsub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, a} + {1'b0, PM} - {1'b0, b};
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] t;
    t = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    t = t % {{W{1'b0}}, PM};
    return t[W-1:0];
  endfunction

  // Fermat inverse a^(p-2); p is prime
  function automatic logic [W-1:0] finv(input logic [W-1:0] a);
    logic [W-1:0] r, b, e;
    r = W'(1);
    b = a;
    e = PM - W'(2);
    for (int unsigned i = 0; i < W; i++) begin
      if (e[i]) r = fmul(r, b);
      b = fmul(b, b);
    end
    return r;
  endfunction

  logic [W-1:0] num, den, lam, tx, ty;

  always_comb begin
    inf = 1'b0;
    num = '0;
    den = '0;
    if (x1 == x2) begin
      inf = !((y1 == y2) && (y1 != '0));
      num = fadd(fmul(THREE, fmul(x1, x1)), AC);
      den = fadd(y1, y1);
    end else begin
      num = fsub(y2, y1);
      den = fsub(x2, x1);
    end
    lam = fmul(num, finv(den));
    tx  = fsub(fsub(fmul(lam, lam), x1), x2);
    ty  = fsub(fmul(lam, fsub(x1, tx)), y1);
    x3  = inf ? '0 : tx;
    y3  = inf ? '0 : ty;
  end
endmodule

module eceg_encryptor #(
  parameter int KWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [KWIDTH-1:0]     k,
  input  logic [`DATAWIDTH-1:0] Gx,
  input  logic [`DATAWIDTH-1:0] Gy,
  input  logic [`DATAWIDTH-1:0] Qx,
  input  logic [`DATAWIDTH-1:0] Qy,
  input  logic [`DATAWIDTH-1:0] Mx,
  input  logic [`DATAWIDTH-1:0] My,
  output logic                  busy,
  output logic                  done,
  output logic [`DATAWIDTH-1:0] C1x_out,
  output logic [`DATAWIDTH-1:0] C1y_out,
  output logic                  C1_inf,
  output logic [`DATAWIDTH-1:0] C2x_out,
  output logic [`DATAWIDTH-1:0] C2y_out
);
  localparam int W  = `DATAWIDTH;
  localparam int IW = (KWIDTH > 1) ? $clog2(KWIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DBL, ADD, MSG} state_t;
  state_t state;

  logic [KWIDTH-1:0] k_r;
  logic [IW-1:0]     idx;
  logic [W-1:0]      gx_r, gy_r, qx_r, qy_r, mx_r, my_r;
  logic [W-1:0]      a1x, a1y, a2x, a2y;
  logic              a1_inf, a2_inf;

  // Second adder operand: self in DBL, base in ADD, message (A2 only) in MSG
  logic [W-1:0] op1x, op1y, op2x, op2y;
  logic [W-1:0] s1x, s1y, s2x, s2y;
  logic         s1_inf, s2_inf;

  always_comb begin
    op1x = gx_r;
    op1y = gy_r;
    op2x = qx_r;
    op2y = qy_r;
    if (state == DBL) begin
      op1x = a1x;
      op1y = a1y;
      op2x = a2x;
      op2y = a2y;
    end else if (state == MSG) begin
      op2x = mx_r;
      op2y = my_r;
    end
  end

  PointAdder add1 (.x1(a1x), .y1(a1y), .x2(op1x), .y2(op1y), .x3(s1x), .y3(s1y), .inf(s1_inf));
  PointAdder add2 (.x1(a2x), .y1(a2y), .x2(op2x), .y2(op2y), .x3(s2x), .y3(s2y), .inf(s2_inf));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      C1x_out <= '0;
      C1y_out <= '0;
      C1_inf  <= 1'b0;
      C2x_out <= '0;
      C2y_out <= '0;
      k_r     <= '0;
      idx     <= '0;
      gx_r    <= '0;
      gy_r    <= '0;
      qx_r    <= '0;
      qy_r    <= '0;
      mx_r    <= '0;
      my_r    <= '0;
      a1x     <= '0;
      a1y     <= '0;
      a2x     <= '0;
      a2y     <= '0;
      a1_inf  <= 1'b1;
      a2_inf  <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            k_r    <= k;
            gx_r   <= Gx;
            gy_r   <= Gy;
            qx_r   <= Qx;
            qy_r   <= Qy;
            mx_r   <= Mx;
            my_r   <= My;
            idx    <= IW'(KWIDTH - 1);
            a1_inf <= 1'b1;
            a2_inf <= 1'b1;
            busy   <= 1'b1;
            state  <= DBL;
          end
        end
        DBL: begin
          if (!a1_inf) begin
            a1x    <= s1x;
            a1y    <= s1y;
            a1_inf <= s1_inf;
          end
          if (!a2_inf) begin
            a2x    <= s2x;
            a2y    <= s2y;
            a2_inf <= s2_inf;
          end
`ifdef ECEG_CONSTTIME_EN
          state <= ADD;
`else
          // Zero bits need no add cycle: advance straight to the next bit
          if (k_r[idx])          state <= ADD;
          else if (idx == '0)    state <= MSG;
          else begin
            idx   <= idx - 1'b1;
            state <= DBL;
          end
`endif
        end
        ADD: begin
          if (k_r[idx]) begin
            if (a1_inf) begin
              a1x    <= gx_r;
              a1y    <= gy_r;
              a1_inf <= 1'b0;
            end else begin
              a1x    <= s1x;
              a1y    <= s1y;
              a1_inf <= s1_inf;
            end
            if (a2_inf) begin
              a2x    <= qx_r;
              a2y    <= qy_r;
              a2_inf <= 1'b0;
            end else begin
              a2x    <= s2x;
              a2y    <= s2y;
              a2_inf <= s2_inf;
            end
          end
          if (idx == '0) state <= MSG;
          else begin
            idx   <= idx - 1'b1;
            state <= DBL;
          end
        end
        MSG: begin
          C1x_out <= a1_inf ? '0 : a1x;
          C1y_out <= a1_inf ? '0 : a1y;
          C1_inf  <= a1_inf;
          C2x_out <= a2_inf ? mx_r : s2x;
          C2y_out <= a2_inf ? my_r : s2y;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
